keypad_bcd_encoder: RTL and testbench
=====================================

Name: keypad_bcd_encoder

Overview:
- Scans a 4x4 matrix keypad and debounces the key it finds.
- Encodes each accepted key press as a 4-bit code plus a one-cycle valid strobe.
- Digits 0-9 produce plain BCD codes, which feed the time/alarm-setting logic upstream of the BCD-to-segment display path.
- This is the input-side counterpart of the display decoder: it produces BCD digits where the decoder consumes them.

Parameters:
- SCAN_DIV, 1000: clk cycles each column is driven before row_in is sampled. Legal range ≥2.
- DEBOUNCE, 4: consecutive identical scan rounds needed to accept a press or a release. Legal range ≥2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- row_in  input  4  keypad rows; active-low, externally pulled up; treated as synchronous to clk.
- col_out  output  4  keypad column drive; active-low one-hot.
- key_code  output  4  code of the last accepted key.
- key_valid  output  1  one-cycle pulse on each accepted press.
- key_held  output  1  high while the accepted key is considered down.
- key_is_digit  output  1  high when key_code ≤ 9.

Behaviour:
- Reset values (while reset=0): col_out=4'b1110 (col 0 driven), key_code=0, key_valid=0, key_held=0, key_is_digit=1, FSM=IDLE, all counters 0.
- Scan timing:
  - div_cnt counts 0..SCAN_DIV-1 continuously.
  - At div_cnt=SCAN_DIV-1, row_in is sampled for the current column and col_idx advances (3 wraps to 0).
  - col_out = ~(1<<col_idx).
  - Scanning never stops, in every FSM state.
- Round: 4 column samples (col_idx 0..3) = 4*SCAN_DIV cycles. Round result is evaluated at the col 3 sample as:
  - NONE: no row low in any column.
  - SINGLE(code): exactly one row/column intersection low.
  - MULTI: two or more intersections low.
- Key map, row r / col c:
  - r0 = 1, 2, 3, A
  - r1 = 4, 5, 6, B
  - r2 = 7, 8, 9, C
  - r3 = *, 0, #, D
- Codes: digits = their value; A=10, B=11, C=12, D=13, *=14, #=15.
- FSM, evaluated at round end only:
  - IDLE:
    - SINGLE(k) → CONFIRM with cand=k, cnt=1.
    - Otherwise stay in IDLE.
  - CONFIRM:
    - SINGLE(cand) → cnt+1. When cnt reaches DEBOUNCE: go to PRESSED, key_code←cand, key_valid=1 for exactly one cycle, key_held←1.
    - SINGLE(other) → stay in CONFIRM, cand=other, cnt=1.
    - NONE or MULTI → IDLE.
  - PRESSED:
    - NONE → RELEASE with cnt=1.
    - SINGLE or MULTI → stay in PRESSED. A second key, or sliding to a new key, does not generate a new press.
  - RELEASE:
    - NONE → cnt+1. When cnt reaches DEBOUNCE: go to IDLE, key_held←0.
    - Any key → PRESSED (cnt cleared, no new key_valid).
- Latency:
  - key_valid and key_held rise on the clk edge that evaluates the DEBOUNCE-th matching round, i.e. the same edge as that round's col 3 sample.
  - key_code and key_is_digit update on that same edge.
- Output hold:
  - key_code and key_is_digit hold their value until the next accepted press.
  - key_valid is never high for two consecutive cycles.
- Reset asserted mid-operation immediately forces all reset values, including mid-dwell and mid-debounce. Scanning restarts at col 0 with div_cnt=0 on the first edge after release.
- Counter widths: div_cnt is $clog2(SCAN_DIV) bits; cnt is $clog2(DEBOUNCE+1) bits; neither wraps past its limit.

Test Plan:
- SCAN_DIV=4, DEBOUNCE=3:
  - Hold key "5" (row1 low whenever col1 is driven) from reset release.
  - Required: key_valid exactly one pulse at the end of round 3 (edge 48 after reset deassert), key_code=5, key_is_digit=1, key_held=1.
- Same setup, release "5":
  - Required: key_held stays 1 for 2 NONE rounds, then drops to 0 at the 3rd NONE round end; no key_valid during release.
- Press "#" for 2 rounds, then release:
  - Required: no key_valid, FSM back in IDLE, key_code unchanged.
  - Then press "#" for 3 rounds → key_code=15, key_is_digit=0, one pulse.
- Bounce case: "7" for 1 round, NONE for 1 round, "7" for 2 rounds.
  - Required: no pulse.
  - A 3rd consecutive "7" round → one pulse, key_code=7.
- Hold "1", then additionally press "2" (MULTI) for 5 rounds:
  - Required: single key_valid for "1" only; key_held stays 1; no second pulse.
- Assert reset=0 mid-CONFIRM and mid-PRESSED:
  - Required: col_out=1110 and all outputs at reset values immediately (asynchronously).
  - After reset=1, a held key needs a full 3 rounds before its pulse.

Source files
------------

// File: rtl/keypad_bcd_encoder_if.sv
// keypad_bcd_encoder_if
// Bundles the keypad matrix lines and the encoded-key outputs of the
// keypad encoder.
//   row_in       [3:0] keypad rows, active-low, pulled up externally
//   col_out      [3:0] keypad column drive, active-low one-hot
//   key_code     [3:0] code of the last accepted key
//   key_valid          one-cycle strobe per accepted press
//   key_held           high while the accepted key is considered down
//   key_is_digit       high when key_code <= 9
// The master modport is the encoder; the slave modport is the keypad/consumer side.
interface keypad_bcd_encoder_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       key_is_digit;

    modport master (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_held,
        output key_is_digit
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  key_is_digit
    );
endinterface

// File: rtl/keypad_bcd_encoder.sv
// keypad_bcd_encoder
// Scans a 4x4 matrix keypad one column at a time, classifies every full
// scan round as no key / one key / several keys, debounces a single key
// over DEBOUNCE identical rounds and reports it as a 4-bit code with a
// one-cycle valid strobe. Digits 0-9 come out as plain BCD.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous reset, active low
//   kp     keypad_bcd_encoder_if.master (row_in, col_out, key_code,
//          key_valid, key_held, key_is_digit)
module keypad_bcd_encoder #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    keypad_bcd_encoder_if.master        kp
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONFIRM = 2'd1,
        S_PRESSED = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // Key map indexed by row*4 + col.
    function automatic logic [3:0] code_of(input logic [3:0] idx);
        case (idx)
            4'd0:  code_of = 4'd1;
            4'd1:  code_of = 4'd2;
            4'd2:  code_of = 4'd3;
            4'd3:  code_of = 4'd10;
            4'd4:  code_of = 4'd4;
            4'd5:  code_of = 4'd5;
            4'd6:  code_of = 4'd6;
            4'd7:  code_of = 4'd11;
            4'd8:  code_of = 4'd7;
            4'd9:  code_of = 4'd8;
            4'd10: code_of = 4'd9;
            4'd11: code_of = 4'd12;
            4'd12: code_of = 4'd14;
            4'd13: code_of = 4'd0;
            4'd14: code_of = 4'd15;
            default: code_of = 4'd13;
        endcase
    endfunction

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [15:0]      hits_q, hits_d;
    state_t           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;
    logic             key_is_digit_q, key_is_digit_d;

    logic             sample;
    logic             round_end;
    logic [15:0]      round_hits;
    logic             is_none;
    logic             is_single;
    logic [3:0]       round_code;
    logic [CNT_W-1:0] cnt_inc;
    logic             press_done;
    logic             rel_done;

    assign sample    = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    assign round_end = sample && (col_idx_q == 2'd3);
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // Intersections seen so far this round, merged with the column being
    // driven right now; only meaningful on a sample cycle.
    always_comb begin
        round_hits = hits_q;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (col_idx_q == 2'(c)) begin
                    round_hits[r*4 + c] = ~kp.row_in[r];
                end
            end
        end
    end

    // Scan divider / column walker; runs in every FSM state.
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        col_idx_d = col_idx_q;
        hits_d    = hits_q;
        if (sample) begin
            div_cnt_d = '0;
            col_idx_d = col_idx_q + 2'd1;
            hits_d    = (col_idx_q == 2'd3) ? 16'd0 : round_hits;
        end
    end

    // Round classification: a power-of-two hit vector means exactly one key.
    assign is_none   = (round_hits == 16'd0);
    assign is_single = !is_none && ((round_hits & (round_hits - 16'd1)) == 16'd0);

    always_comb begin
        round_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (round_hits[i]) begin
                round_code = code_of(4'(i));
            end
        end
    end

    assign press_done = round_end && (state_q == S_CONFIRM) && is_single &&
                        (round_code == cand_q) && (cnt_inc == CNT_W'(DEBOUNCE));
    assign rel_done   = round_end && (state_q == S_RELEASE) && is_none &&
                        (cnt_inc == CNT_W'(DEBOUNCE));

    // State register (all flops).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q      <= '0;
            col_idx_q      <= 2'd0;
            hits_q         <= 16'd0;
            state_q        <= S_IDLE;
            cand_q         <= 4'd0;
            cnt_q          <= '0;
            key_code_q     <= 4'd0;
            key_valid_q    <= 1'b0;
            key_held_q     <= 1'b0;
            key_is_digit_q <= 1'b1;
        end else begin
            div_cnt_q      <= div_cnt_d;
            col_idx_q      <= col_idx_d;
            hits_q         <= hits_d;
            state_q        <= state_d;
            cand_q         <= cand_d;
            cnt_q          <= cnt_d;
            key_code_q     <= key_code_d;
            key_valid_q    <= key_valid_d;
            key_held_q     <= key_held_d;
            key_is_digit_q <= key_is_digit_d;
        end
    end

    // Next-state logic; the FSM only moves at round end.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        if (round_end) begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_single) begin
                        state_d = S_CONFIRM;
                        cand_d  = round_code;
                        cnt_d   = CNT_W'(1);
                    end
                end
                S_CONFIRM: begin
                    if (is_single && (round_code == cand_q)) begin
                        if (cnt_inc == CNT_W'(DEBOUNCE)) begin
                            state_d = S_PRESSED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (is_single) begin
                        cand_d = round_code;
                        cnt_d  = CNT_W'(1);
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                S_PRESSED: begin
                    // Extra or different keys while held are ignored.
                    if (is_none) begin
                        state_d = S_RELEASE;
                        cnt_d   = CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (is_none) begin
                        if (cnt_inc == CNT_W'(DEBOUNCE)) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = S_PRESSED;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output logic: registered so all outputs change on the accepting edge.
    always_comb begin
        key_code_d     = key_code_q;
        key_is_digit_d = key_is_digit_q;
        key_valid_d    = press_done;
        key_held_d     = key_held_q;
        if (press_done) begin
            key_code_d     = cand_q;
            key_is_digit_d = (cand_q <= 4'd9);
            key_held_d     = 1'b1;
        end else if (rel_done) begin
            key_held_d = 1'b0;
        end
    end

    assign kp.col_out      = ~(4'b0001 << col_idx_q);
    assign kp.key_code     = key_code_q;
    assign kp.key_valid    = key_valid_q;
    assign kp.key_held     = key_held_q;
    assign kp.key_is_digit = key_is_digit_q;
endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// tb_keypad_bcd_encoder
// Drives a simulated 4x4 keypad round by round, predicts press/release
// events with a run-length reference model and checks them from an
// independent monitor through an event queue.
module tb_keypad_bcd_encoder;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int ROUND    = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pressed = 16'd0;   // bit row*4+col set = key physically down

    keypad_bcd_encoder_if kp();

    keypad_bcd_encoder #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .kp   (kp)
    );

    always #5 clk = ~clk;

    // Keypad: a row reads low when a pressed key on it lies in a driven column.
    always_comb begin
        logic [3:0] rows;
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4 + c] && !kp.col_out[c]) rows[r] = 1'b0;
            end
        end
        kp.row_in = rows;
    end

    typedef struct {
        bit is_press;
        int code;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc;
    bit  prev_held  = 1'b0;
    bit  prev_valid = 1'b0;

    int  key_code_of[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    // Reference model state: run length of identical round results.
    bit  m_held;
    int  m_run_val;
    int  m_run_len;
    int  m_last_code;
    int  round_idx;

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] key(input int idx);
        logic [15:0] one;
        one = 16'd1;
        return one << idx;
    endfunction

    task automatic model_reset();
        m_held      = 1'b0;
        m_run_val   = -3;
        m_run_len   = 0;
        m_last_code = 0;
        round_idx   = 0;
        exp_q.delete();
    endtask

    task automatic check_reset_values();
        check("rst_col_out", int'(kp.col_out), 4'b1110);
        check("rst_key_code", int'(kp.key_code), 0);
        check("rst_key_valid", int'(kp.key_valid), 0);
        check("rst_key_held", int'(kp.key_held), 0);
        check("rst_key_is_digit", int'(kp.key_is_digit), 1);
    endtask

    // One scan round with a fixed key set; result -1 = none, -2 = several.
    task automatic run_round(input logic [15:0] keys);
        int  res;
        ev_t e;
        pressed = keys;
        res = -1;
        if ($countones(keys) > 1) begin
            res = -2;
        end else begin
            for (int i = 0; i < 16; i++) if (keys[i]) res = key_code_of[i];
        end
        if (res == m_run_val) begin
            m_run_len++;
        end else begin
            m_run_val = res;
            m_run_len = 1;
        end
        if (!m_held && res >= 0 && m_run_len == DEBOUNCE) begin
            m_held      = 1'b1;
            m_last_code = res;
            e.is_press  = 1'b1;
            e.code      = res;
            e.cyc       = ROUND * (round_idx + 1);
            exp_q.push_back(e);
        end else if (m_held && res == -1 && m_run_len == DEBOUNCE) begin
            m_held     = 1'b0;
            e.is_press = 1'b0;
            e.code     = m_last_code;
            e.cyc      = ROUND * (round_idx + 1);
            exp_q.push_back(e);
        end
        round_idx++;
        repeat (ROUND) @(posedge clk);
        #1;
        check("key_held_at_round_end", int'(kp.key_held), int'(m_held));
    endtask

    // Asynchronous reset in the middle of a round, then a clean restart.
    task automatic do_reset(input int extra);
        repeat (extra) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic take_event(input bit is_press);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got %s code=%0d at cycle %0d, expected no event",
                     is_press ? "press" : "release", kp.key_code, cyc);
        end else begin
            e = exp_q.pop_front();
            $display("event %s code=%0d cycle=%0d (expected %s code=%0d cycle=%0d)",
                     is_press ? "press" : "release", kp.key_code, cyc,
                     e.is_press ? "press" : "release", e.code, e.cyc);
            check("event_kind", int'(is_press), int'(e.is_press));
            check("event_cycle", cyc, e.cyc);
            check("key_code", int'(kp.key_code), e.code);
            check("key_is_digit", int'(kp.key_is_digit), (e.code <= 9) ? 1 : 0);
        end
    endtask

    // Monitor: independent of the stimulus, reacts to what the DUT shows.
    always @(negedge clk) begin
        if (!reset) begin
            prev_held  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (kp.key_held && !prev_held) check("held_rise_with_valid", int'(kp.key_valid), 1);
            if (kp.key_valid) begin
                check("valid_one_cycle", int'(prev_valid), 0);
                take_event(1'b1);
            end
            if (prev_held && !kp.key_held) take_event(1'b0);
            prev_held  = kp.key_held;
            prev_valid = kp.key_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, len, a, b;
        logic [15:0] k;

        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values();
        @(negedge clk);
        reset = 1'b1;

        // "5" held from reset release: press at edge 3*ROUND.
        repeat (5) run_round(key(5));
        repeat (3) run_round(16'd0);

        // "#" too short, then long enough.
        repeat (2) run_round(key(14));
        repeat (3) run_round(16'd0);
        check("code_hold_after_short", int'(kp.key_code), m_last_code);
        repeat (3) run_round(key(14));
        repeat (3) run_round(16'd0);

        // Bounce on "7".
        run_round(key(8));
        run_round(16'd0);
        repeat (3) run_round(key(8));
        repeat (3) run_round(16'd0);

        // "1" then "1"+"2".
        repeat (3) run_round(key(0));
        repeat (5) run_round(key(0) | key(1));
        repeat (3) run_round(16'd0);

        // Reset mid-CONFIRM, then mid-PRESSED.
        repeat (2) run_round(key(5));
        do_reset(5);
        repeat (4) run_round(key(5));
        do_reset(7);
        repeat (3) run_round(key(5));
        repeat (3) run_round(16'd0);

        // Every key once.
        for (int i = 0; i < 16; i++) begin
            repeat (3) run_round(key(i));
            repeat (3) run_round(16'd0);
        end

        // Random sequences.
        for (int seg = 0; seg < 40; seg++) begin
            t   = int'($urandom_range(0, 9));
            len = int'($urandom_range(1, 5));
            a   = int'($urandom_range(0, 15));
            b   = (a + 1 + int'($urandom_range(0, 14))) % 16;
            if (t <= 3)      k = 16'd0;
            else if (t <= 8) k = key(a);
            else             k = key(a) | key(b);
            repeat (len) run_round(k);
        end

        repeat (4) run_round(16'd0);
        repeat (10) @(posedge clk);
        check("events_outstanding", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
